// File: rtl/binary_threshold_activation.sv
// Re-binarises signed per-channel accumulations against held per-channel thresholds.
// Each threshold set is reused for REPEAT data beats; the output is registered with valid/ready.
module binary_threshold_activation #(
  parameter int unsigned IN_WIDTH     = 7,
  parameter int unsigned THRESH_WIDTH = 7,
  parameter int unsigned PARALLELISM  = 3,
  parameter int unsigned REPEAT       = 6
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [PARALLELISM-1:0][IN_WIDTH-1:0]      data_in,
  input  logic                                      data_in_valid,
  output logic                                      data_in_ready,
  input  logic [PARALLELISM-1:0][THRESH_WIDTH-1:0]  thresh,
  input  logic [PARALLELISM-1:0]                    thresh_invert,
  input  logic                                      thresh_valid,
  output logic                                      thresh_ready,
  output logic [PARALLELISM-1:0]                    data_out,
  output logic                                      data_out_valid,
  input  logic                                      data_out_ready
);

  localparam int unsigned CntWidth = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(REPEAT - 1);

  typedef enum logic [0:0] {StLoad, StRun} state_e;

  state_e                                   state_q;
  logic [CntWidth-1:0]                      cnt_q;
  logic [PARALLELISM-1:0][THRESH_WIDTH-1:0] thresh_q;
  logic [PARALLELISM-1:0]                   invert_q;
  logic [PARALLELISM-1:0]                   act;
  logic                                     accept;

  assign thresh_ready  = (state_q == StLoad);
  assign data_in_ready = (state_q == StRun) && (!data_out_valid || data_out_ready);
  assign accept        = data_in_valid && data_in_ready;

  for (genvar g = 0; g < int'(PARALLELISM); g++) begin : g_ch
    logic signed [IN_WIDTH-1:0] din;
    logic signed [IN_WIDTH-1:0] thr;
    assign din    = data_in[g];
    assign thr    = IN_WIDTH'($signed(thresh_q[g]));
    // Ties resolve to +1 in both polarities.
    assign act[g] = invert_q[g] ? (din <= thr) : (din >= thr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StLoad;
      cnt_q          <= '0;
      thresh_q       <= '0;
      invert_q       <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
    end else begin
      unique case (state_q)
        StLoad: begin
          if (thresh_valid) begin
            thresh_q <= thresh;
            invert_q <= thresh_invert;
            cnt_q    <= '0;
            state_q  <= StRun;
          end
        end
        StRun: begin
          if (accept) begin
            if (cnt_q == CntLast) begin
              cnt_q   <= '0;
              state_q <= StLoad;
            end else begin
              cnt_q <= cnt_q + CntWidth'(1);
            end
          end
        end
        default: state_q <= StLoad;
      endcase

      // A pending last beat of a set survives the following threshold load untouched.
      if (accept) begin
        data_out       <= act;
        data_out_valid <= 1'b1;
      end else if (data_out_ready) begin
        data_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_binary_threshold_activation.sv
// Directed and randomized checks of binary_threshold_activation against an integer sign model.
module tb_binary_threshold_activation;

  localparam int IW  = 7;
  localparam int TW  = 7;
  localparam int P   = 3;
  localparam int R   = 6;
  localparam int DW  = P * IW;
  localparam int TDW = P * TW;

  typedef logic [P-1:0][IW-1:0] dvec_t;
  typedef logic [P-1:0][TW-1:0] tvec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  dvec_t        data_in = '0;
  logic         data_in_valid = 1'b0;
  logic         data_in_ready;
  tvec_t        thresh = '0;
  logic [P-1:0] thresh_invert = '0;
  logic         thresh_valid = 1'b0;
  logic         thresh_ready;
  logic [P-1:0] data_out;
  logic         data_out_valid;
  logic         data_out_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  tvec_t        cur_t;
  logic [P-1:0] cur_inv;

  binary_threshold_activation #(
    .IN_WIDTH    (IW),
    .THRESH_WIDTH(TW),
    .PARALLELISM (P),
    .REPEAT      (R)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_in_ready (data_in_ready),
    .thresh        (thresh),
    .thresh_invert (thresh_invert),
    .thresh_valid  (thresh_valid),
    .thresh_ready  (thresh_ready),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Sign model: +1 when the accumulation is on the threshold's side, ties give +1.
  function automatic logic [P-1:0] model(input dvec_t d, input tvec_t t, input logic [P-1:0] inv);
    logic [P-1:0] b;
    for (int i = 0; i < P; i++) begin
      int dv;
      int tv;
      dv = $signed(d[i]);
      tv = $signed(t[i]);
      b[i] = inv[i] ? (dv <= tv) : (dv >= tv);
    end
    return b;
  endfunction

  function automatic dvec_t mk_d(input int a, input int b, input int c);
    dvec_t v;
    v[0] = IW'(a);
    v[1] = IW'(b);
    v[2] = IW'(c);
    return v;
  endfunction

  function automatic tvec_t mk_t(input int a, input int b, input int c);
    tvec_t v;
    v[0] = TW'(a);
    v[1] = TW'(b);
    v[2] = TW'(c);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_set(input tvec_t t, input logic [P-1:0] inv);
    int n;
    n = 0;
    while (!thresh_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("thresh_ready_wait", thresh_ready, 1'b1);
    thresh        = t;
    thresh_invert = inv;
    thresh_valid  = 1'b1;
    cur_t         = t;
    cur_inv       = inv;
    @(posedge clk); #1;
    thresh_valid = 1'b0;
    chk("run_after_load", thresh_ready, 1'b0);
  endtask

  task automatic beat(input dvec_t d, input logic [P-1:0] exp);
    data_in        = d;
    data_in_valid  = 1'b1;
    data_out_ready = 1'b1;
    #1;
    chk("in_ready", data_in_ready, 1'b1);
    @(posedge clk); #1;
    chk("out_valid", data_out_valid, 1'b1);
    chk("out_bits", data_out, exp);
  endtask

  task automatic rand_beat();
    dvec_t d;
    d = DW'($urandom);
    beat(d, model(d, cur_t, cur_inv));
  endtask

  logic [P-1:0] q[$];
  dvec_t        d7, d8;
  logic [P-1:0] exp7;
  int           loaded, beats, cyc;

  initial begin
    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_out_valid", data_out_valid, 1'b0);
    chk("rst_out", data_out, '0);
    chk("rst_thresh_ready", thresh_ready, 1'b1);
    chk("rst_in_ready", data_in_ready, 1'b0);
    rst = 1'b0;

    // Basic compare, then the rest of the set back-to-back
    load_set(mk_t(2, 0, -3), 3'b100);
    beat(mk_d(2, -1, -3), 3'b101);
    repeat (R - 1) rand_beat();

    // Repeat boundary: a 7th beat stalls until new thresholds are loaded
    d7 = DW'($urandom);
    data_in = d7;
    #1;
    chk("bound_in_ready", data_in_ready, 1'b0);
    chk("bound_thresh_ready", thresh_ready, 1'b1);
    repeat (2) begin
      @(posedge clk); #1;
      chk("stall_in_ready", data_in_ready, 1'b0);
      chk("stall_out_valid", data_out_valid, 1'b0);
    end
    load_set(tvec_t'(TDW'($urandom)), P'($urandom));
    exp7 = model(d7, cur_t, cur_inv);
    beat(d7, exp7);

    // Back-pressure: output held, no accept, counter frozen
    d8 = DW'($urandom);
    data_in        = d8;
    data_out_ready = 1'b0;
    #1;
    chk("bp_in_ready", data_in_ready, 1'b0);
    repeat (4) begin
      @(posedge clk); #1;
      chk("bp_out_hold", data_out, exp7);
      chk("bp_out_valid", data_out_valid, 1'b1);
      chk("bp_in_ready_hold", data_in_ready, 1'b0);
    end
    beat(d8, model(d8, cur_t, cur_inv));
    repeat (R - 2) rand_beat();
    chk("bp_set_end_thresh_ready", thresh_ready, 1'b1);
    chk("bp_set_end_in_ready", data_in_ready, 1'b0);

    // Extremes of the 7-bit signed range
    load_set(mk_t(-64, 63, -64), 3'b110);
    beat(mk_d(-64, 63, 63), 3'b011);
    beat(mk_d(63, -64, -64), 3'b111);
    repeat (R - 2) rand_beat();
    load_set(mk_t(63, 63, -64), 3'b000);
    beat(mk_d(63, 62, -64), 3'b101);
    repeat (R - 1) rand_beat();

    // Asynchronous reset mid-set with an output pending
    load_set(tvec_t'(TDW'($urandom)), P'($urandom));
    repeat (3) rand_beat();
    data_in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", data_out_valid, 1'b0);
    chk("arst_thresh_ready", thresh_ready, 1'b1);
    chk("arst_in_ready", data_in_ready, 1'b0);
    #10;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("arst_still_load", thresh_ready, 1'b1);
    load_set(tvec_t'(TDW'($urandom)), P'($urandom));
    repeat (R) rand_beat();
    data_in_valid = 1'b0;
    chk("arst_full_set", thresh_ready, 1'b1);
    @(posedge clk); #1;
    chk("drain_valid", data_out_valid, 1'b0);

    // Random scoreboard over 50 threshold sets
    loaded = 0;
    beats  = 0;
    cyc    = 0;
    while (!(loaded == 50 && beats == R && q.size() == 0) && cyc < 20000) begin
      thresh_valid   = (loaded < 50) && ($urandom_range(0, 2) == 0);
      thresh         = tvec_t'(TDW'($urandom));
      thresh_invert  = P'($urandom);
      data_in_valid  = ($urandom_range(0, 3) != 0);
      data_in        = DW'($urandom);
      data_out_ready = ($urandom_range(0, 3) != 0);
      #3;
      if (data_out_valid && data_out_ready) begin
        chk("rand_q_nonempty", q.size() != 0, 1'b1);
        if (q.size() != 0) chk("rand_out", data_out, q.pop_front());
      end
      if (thresh_valid && thresh_ready) begin
        if (loaded > 0) chk("rand_set_beats", beats, R);
        cur_t   = thresh;
        cur_inv = thresh_invert;
        beats   = 0;
        loaded++;
      end
      if (data_in_valid && data_in_ready) begin
        chk("rand_beat_in_set", beats < R, 1'b1);
        q.push_back(model(data_in, cur_t, cur_inv));
        beats++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("rand_done", cyc < 20000, 1'b1);
    chk("rand_last_set_beats", beats, R);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/binary_threshold_activation.md
Name: binary_threshold_activation

Overview:
- Downstream stage of the binary-activation binary convolution.
- Consumes the signed per-output-channel accumulations (popcount plus bias) and re-binarises them against per-channel thresholds (folded batch-norm plus sign), producing 1-bit activations for the next binary layer.
- Threshold sets arrive on their own handshake; each set is held and reused for REPEAT output pixels before a new set is loaded.
- Output is registered, with full-throughput valid/ready.

Parameters:
- IN_WIDTH, 7, width of each signed accumulation in data_in (matches the convolution's uncast output width).
- THRESH_WIDTH, 7, width of each signed threshold; must satisfy THRESH_WIDTH <= IN_WIDTH.
- PARALLELISM, 3, channels per beat (equals the convolution's OUT_CHANNELS).
- REPEAT, 6, data beats per threshold set (out_width*out_height); must be >= 1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- data_in  in  IN_WIDTH x [PARALLELISM]  signed accumulations, one per channel.
- data_in_valid  in  1  data handshake.
- data_in_ready  out  1  data handshake.
- thresh  in  THRESH_WIDTH x [PARALLELISM]  signed per-channel thresholds.
- thresh_invert  in  PARALLELISM  per-channel comparison flip (negative BN gamma).
- thresh_valid  in  1  threshold handshake.
- thresh_ready  out  1  threshold handshake.
- data_out  out  1 x [PARALLELISM]  binary activations; 1 encodes +1, 0 encodes -1.
- data_out_valid  out  1  output handshake.
- data_out_ready  in  1  output handshake.

Behaviour:
- Reset is asynchronous and active-high: clk, rst. On rst:
  - state=LOAD, beat counter=0, threshold and invert registers=0.
  - data_out=0, data_out_valid=0, thresh_ready=1, data_in_ready=0.
- Reset asserted mid-operation discards the held thresholds, any partial repeat count and any pending output beat. After reset the block needs a fresh threshold set.
- FSM states:
  - LOAD: thresh_ready=1, data_in_ready=0. On thresh_valid&&thresh_ready, latch thresh and thresh_invert, clear the counter and go to RUN.
  - RUN: thresh_ready=0, data_in_ready=(!data_out_valid || data_out_ready).
    - On each accepted data beat, the counter increments.
    - On the beat where the counter==REPEAT-1, the counter clears and the state returns to LOAD the next cycle.
    - No threshold is accepted in the cycle of that last beat; thresh_ready rises in the following cycle.
- Compare, per channel i:
  - Sign-extend thresh[i] to IN_WIDTH; the compare is signed.
  - bit = thresh_invert[i] ? (data_in[i] <= t[i]) : (data_in[i] >= t[i]).
  - Equality maps to 1 when not inverted and to 1 when inverted; ties always give +1.
- Output register:
  - Latency 1 cycle from the accepted data beat to data_out_valid.
  - data_out and data_out_valid load on an accepted data beat.
  - data_out_valid clears when data_out_ready is high and no new beat is accepted.
  - data_out holds stable while data_out_valid && !data_out_ready.
  - Throughput is 1 beat/cycle in RUN with data_out_ready held high.
- Back-pressure: data_in_ready depends combinationally on data_out_ready; no other combinational input-to-output path exists.
- Simultaneous events:
  - Output drain and new accept in the same cycle: the register takes the new beat and data_out_valid stays 1.
  - The last beat of a set may still be pending on the output while the next threshold set is loaded; loading does not disturb data_out.
- REPEAT=1: every accepted data beat is followed by a LOAD cycle.
- Thresholds are not double-buffered; one bubble cycle of data input occurs per set at minimum.

Test Plan:
1. Basic compare: reset; load thresh={2,0,-3}, invert={0,0,1}; feed data {2,-1,-3} -> data_out={1,0,1} one cycle after acceptance, data_out_valid=1.
2. Repeat boundary: REPEAT=6, data_out_ready=1; stream 6 beats back-to-back -> 6 outputs on consecutive cycles. Then data_in_ready=0 and thresh_ready=1. A 7th beat offered stalls until a new set is accepted, and uses the new thresholds.
3. Back-pressure: hold data_out_ready=0 for 4 cycles with a pending beat -> data_out stable, data_in_ready=0, counter unchanged. Release -> the next beat is accepted in the same cycle as the drain.
4. Extremes: IN_WIDTH=7 data -64 and 63 against thresh -64 and 63, both invert settings -> -64>=-64 gives 1; 63>=63 gives 1; -64<=63 inverted gives 1; 63<=-64 inverted gives 0.
5. Reset mid-set: after 3 of 6 beats with an output pending, assert rst asynchronously -> data_out_valid=0 immediately, thresh_ready=1, data_in_ready=0. A new set then yields a full 6-beat repeat.
6. Random scoreboard: random thresholds, inverts, data and ready toggling over 50 sets -> output stream bit-exact against the reference sign model; beat count per set equals REPEAT.
